lfsr_whitening: RTL and testbench

Parametrised LFSR whitening/dewhitening engine for the camera-FPGA bit path. It is the successor to the fixed 7-bit, 50-samples-per-bit dewhitener. It generalises LFSR length, tap polynomial, seed and samples-per-bit. It adds runtime selection of additive, self-synchronising scramble and self-synchronising descramble modes, plus seed loading, a bit strobe and a per-frame bit counter. It sits between the oversampled bit slicer and the frame parser, and can run in reverse in the transmit/loopback path.

---
 rtl/lfsr_whitening.sv | 111 +++++++++++
 tb/tb_lfsr_whitening.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_whitening.sv
`timescale 1ns/1ps
// LFSR whitening/dewhitening engine: additive or self-synchronising
// scrambling of an oversampled bit stream, one bit every SPB samples.
module lfsr_whitening #(
    parameter int unsigned         LFSR_LEN = 7,
    parameter logic [LFSR_LEN-1:0] TAPS     = 7'b1001000,
    parameter logic [LFSR_LEN-1:0] SEED     = '0,
    parameter int unsigned         SPB      = 50
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic                seed_load,
    input  logic [LFSR_LEN-1:0] seed,
    input  logic                in_bit,
    output logic                out_bit,
    output logic                bit_strobe,
    output logic [15:0]         bit_count
);

    localparam logic [1:0]  MODE_PASS = 2'd0;
    localparam logic [1:0]  MODE_ADD  = 2'd1;
    localparam logic [1:0]  MODE_SCR  = 2'd2;
    localparam logic [1:0]  MODE_DSC  = 2'd3;
    localparam logic [15:0] CNT_LAST  = 16'(SPB - 1);

    logic [LFSR_LEN-1:0] r_state;
    logic [15:0]         r_count;
    logic [15:0]         r_bits;
    logic [1:0]          r_mode;
    logic                r_active;
    logic                r_out;
    logic                r_strobe;

    logic                w_first;
    logic [1:0]          w_mode;
    logic                w_f;
    logic                w_tick;
    logic                w_out;
    logic                w_fb;
    logic [LFSR_LEN-1:0] w_next;
    logic [15:0]         w_count_next;
    logic [15:0]         w_bits_next;

    // The mode input is only honoured on the first enabled cycle of a frame.
    assign w_first      = enable & ~r_active;
    assign w_mode       = w_first ? mode : r_mode;
    assign w_f          = ^(r_state & TAPS);
    assign w_tick       = enable && (r_count == 16'd0);
    assign w_count_next = (r_count == CNT_LAST) ? 16'd0 : r_count + 16'd1;
    assign w_bits_next  = w_first ? 16'd1 :
                          (r_bits == 16'hFFFF) ? r_bits : r_bits + 16'd1;

    always_comb begin
        w_out  = in_bit ^ w_f;
        w_fb   = w_f;
        w_next = r_state;
        unique case (w_mode)
            MODE_PASS: w_out = in_bit;
            MODE_ADD:  w_fb  = w_f;
            MODE_SCR:  w_fb  = in_bit ^ w_f;
            MODE_DSC:  w_fb  = in_bit;
        endcase
        if (w_mode != MODE_PASS) begin
            w_next = {r_state[LFSR_LEN-2:0], w_fb};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= SEED;
            r_count  <= 16'd0;
            r_bits   <= 16'd0;
            r_mode   <= MODE_PASS;
            r_active <= 1'b0;
            r_out    <= 1'b0;
            r_strobe <= 1'b0;
        end else if (seed_load) begin
            r_state  <= seed;
            r_count  <= 16'd0;
            r_bits   <= 16'd0;
            r_strobe <= 1'b0;
            if (w_first) begin
                r_active <= 1'b1;
                r_mode   <= mode;
            end
        end else if (!enable) begin
            r_state  <= SEED;
            r_count  <= 16'd0;
            r_active <= 1'b0;
            r_out    <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_active <= 1'b1;
            r_mode   <= w_mode;
            r_count  <= w_count_next;
            r_strobe <= w_tick;
            if (w_tick) begin
                r_state <= w_next;
                r_out   <= w_out;
                r_bits  <= w_bits_next;
            end
        end
    end

    assign out_bit    = r_out;
    assign bit_strobe = r_strobe;
    assign bit_count  = r_bits;

endmodule

// File: tb/tb_lfsr_whitening.sv
`timescale 1ns/1ps
// Scoreboard bench for lfsr_whitening: legacy SPB=50 instance plus an
// SPB=1 scrambler feeding an SPB=1 descrambler.
module tb_lfsr_whitening;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       en_l, sl_l, in_l, out_l, str_l;
    logic [1:0] mode_l;
    logic [6:0] seed_l;
    logic [15:0] bc_l;

    logic       en_a, sl_a, in_a, out_a, str_a;
    logic [1:0] mode_a;
    logic [6:0] seed_a;
    logic [15:0] bc_a;

    logic       en_b, sl_b, out_b, str_b;
    logic [1:0] mode_b;
    logic [6:0] seed_b;
    logic [15:0] bc_b;

    lfsr_whitening u_leg (
        .clock(clk), .reset(rst_n), .enable(en_l), .mode(mode_l),
        .seed_load(sl_l), .seed(seed_l), .in_bit(in_l),
        .out_bit(out_l), .bit_strobe(str_l), .bit_count(bc_l)
    );

    lfsr_whitening #(.SPB(1)) u_a (
        .clock(clk), .reset(rst_n), .enable(en_a), .mode(mode_a),
        .seed_load(sl_a), .seed(seed_a), .in_bit(in_a),
        .out_bit(out_a), .bit_strobe(str_a), .bit_count(bc_a)
    );

    lfsr_whitening #(.SPB(1)) u_b (
        .clock(clk), .reset(rst_n), .enable(en_b), .mode(mode_b),
        .seed_load(sl_b), .seed(seed_b), .in_bit(out_a),
        .out_bit(out_b), .bit_strobe(str_b), .bit_count(bc_b)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: x^7+x^4+1 feedback from state bits 6 and 3.
    function automatic logic [7:0] ref_step(input logic [6:0] st,
                                            input logic [1:0] m,
                                            input logic b);
        logic f, o, fb;
        if (m == 2'd0) return {b, st};
        f  = st[6] ^ st[3];
        o  = b ^ f;
        fb = (m == 2'd1) ? f : (m == 2'd2) ? o : b;
        return {o, st[5:0], fb};
    endfunction

    logic       q_l[$];
    logic       q_a[$];
    logic       q_r[$];
    logic [6:0] lst;
    int         lcyc, lbits, lstrb;

    // kind: 0 keep in_l, no push; 1 random; 2 choose in_l so out is 1
    task automatic leg_step(input int kind);
        logic [7:0] r;
        if (lcyc % 50 == 0) begin
            if (kind == 1) in_l = 1'($urandom_range(0, 1));
            if (kind == 2) in_l = ~(lst[6] ^ lst[3]);
            r   = ref_step(lst, 2'd2, in_l);
            lst = r[6:0];
            if (kind != 0) q_l.push_back(r[7]);
            lbits++;
        end
        @(posedge clk);
        @(negedge clk);
        if (str_l) begin
            lstrb++;
            chk("leg_strobe_phase", lcyc % 50, 0);
            if (q_l.size() == 0) chk("leg_sb_empty", 1, 0);
            else chk("leg_out", out_l, q_l.pop_front());
        end
        lcyc++;
    endtask

    task automatic leg_frame_start();
        lst   = 7'h00;
        lcyc  = 0;
        lbits = 0;
        lstrb = 0;
    endtask

    logic prbs[254];

    initial begin
        logic [7:0] r;
        logic [6:0] ast;
        int         nstr, mism, ones, idle;

        rst_n  = 1'b0;
        en_l = 0; sl_l = 0; in_l = 0; mode_l = 2'd2; seed_l = '0;
        en_a = 0; sl_a = 0; in_a = 0; mode_a = 2'd0; seed_a = '0;
        en_b = 0; sl_b = 0; mode_b = 2'd0; seed_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_out", out_l, 0);
        chk("rst_strobe", str_l, 0);
        chk("rst_bcnt", bc_l, 0);
        rst_n = 1'b1;

        // Additive PRBS from seed 7F
        @(negedge clk);
        en_a = 1; mode_a = 2'd1; sl_a = 1; seed_a = 7'h7F; in_a = 0;
        @(posedge clk);
        @(negedge clk);
        chk("prbs_load_nostrobe", str_a, 0);
        sl_a = 0;
        ast  = 7'h7F;
        nstr = 0;
        for (int i = 0; i < 254; i++) begin
            r   = ref_step(ast, 2'd1, 1'b0);
            ast = r[6:0];
            q_a.push_back(r[7]);
            @(posedge clk);
            @(negedge clk);
            if (str_a) begin
                nstr++;
                chk("prbs_out", out_a, q_a.pop_front());
            end
            prbs[i] = out_a;
        end
        chk("prbs_strobes", nstr, 254);
        chk("prbs_sb_drain", q_a.size(), 0);
        mism = 0;
        ones = 0;
        for (int i = 0; i < 127; i++) begin
            if (prbs[i] !== prbs[i+127]) mism++;
            if (prbs[i] === 1'b1) ones++;
        end
        chk("prbs_period127", mism, 0);
        chk("prbs_ones", ones, 64);

        // Round trip, equal seeds
        en_a = 0;
        @(posedge clk);
        @(negedge clk);
        en_a = 1; en_b = 1; mode_a = 2'd2; mode_b = 2'd3;
        for (int k = 0; k < 1000; k++) begin
            in_a = 1'($urandom_range(0, 1));
            q_r.push_back(in_a);
            @(posedge clk);
            @(negedge clk);
            if (k >= 1) chk("rt_eq", out_b, q_r.pop_front());
        end

        // Round trip, descrambler seeded 55: locks after 7 bits
        en_a = 0; en_b = 0;
        @(posedge clk);
        @(negedge clk);
        q_r.delete();
        en_a = 1; en_b = 1; sl_b = 1; seed_b = 7'h55;
        for (int k = 0; k < 300; k++) begin
            if (k == 1) sl_b = 0;
            in_a = 1'($urandom_range(0, 1));
            q_r.push_back(in_a);
            @(posedge clk);
            @(negedge clk);
            if (k >= 1) begin
                r[0] = q_r.pop_front();
                if (k - 1 >= 7) chk("rt_sync", out_b, r[0]);
            end
        end
        en_a = 0; en_b = 0;

        // Legacy equivalence
        q_l = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        leg_frame_start();
        in_l = 1; mode_l = 2'd2; en_l = 1;
        repeat (351) leg_step(0);
        chk("leg_bcnt8", bc_l, 8);
        repeat (49) leg_step(0);
        chk("leg_strobes8", lstrb, 8);

        // Mode change mid-frame ignored
        mode_l = 2'd0;
        lstrb  = 0;
        repeat (150) leg_step(1);
        leg_step(2);
        repeat (19) leg_step(1);
        chk("latch_strobes", lstrb, 4);
        chk("pre_drop_out", out_l, 1);

        // Enable dropped at counter 20
        en_l = 0;
        @(posedge clk);
        @(negedge clk);
        chk("drop_out", out_l, 0);
        chk("drop_strobe", str_l, 0);
        chk("drop_bcnt_hold", bc_l, lbits);
        @(posedge clk);
        @(negedge clk);
        en_l = 1; mode_l = 2'd2;
        leg_frame_start();
        leg_step(2);
        chk("reraise_strobe", str_l, 1);
        chk("reraise_bcnt", bc_l, 1);

        // seed_load coincident with enable rising
        en_l = 0;
        @(posedge clk);
        @(negedge clk);
        en_l = 1; sl_l = 1; seed_l = 7'h01;
        @(posedge clk);
        @(negedge clk);
        chk("sl_no_strobe", str_l, 0);
        chk("sl_bcnt", bc_l, 0);
        sl_l = 0;
        leg_frame_start();
        lst = 7'h01;
        leg_step(1);
        chk("sl_first_strobe", str_l, 1);
        repeat (100) leg_step(1);
        chk("sl_strobes", lstrb, 3);

        // Async reset between edges, right after a strobe of a 1
        repeat (49) leg_step(1);
        leg_step(2);
        chk("pre_rst_strobe", str_l, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", out_l, 0);
        chk("arst_strobe", str_l, 0);
        chk("arst_bcnt", bc_l, 0);
        en_l = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle = 0;
        repeat (60) begin
            @(posedge clk);
            @(negedge clk);
            if (str_l) idle++;
        end
        chk("post_rst_idle", idle, 0);
        chk("leg_sb_drain", q_l.size(), 0);
        en_l = 1; mode_l = 2'd2;
        leg_frame_start();
        leg_step(2);
        chk("post_rst_first", str_l, 1);
        chk("post_rst_bcnt", bc_l, 1);
        chk("leg_sb_final", q_l.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
